// File: rtl/wdt_pkg.sv
// Shared definitions for the APB watchdog: register map, access keys and
// bit positions inside CTRL and STATUS.
package wdt_pkg;

  typedef enum logic [2:0] {
    REG_CTRL   = 3'd0,
    REG_LOAD   = 3'd1,
    REG_VALUE  = 3'd2,
    REG_KICK   = 3'd3,
    REG_STATUS = 3'd4,
    REG_LOCK   = 3'd5,
    REG_RSVD6  = 3'd6,
    REG_RSVD7  = 3'd7
  } reg_e;

  localparam logic [31:0] KICK_KEY   = 32'h5A5A_A5A5;
  localparam logic [31:0] UNLOCK_KEY = 32'h1ACC_E551;

  localparam int CTRL_EN        = 0;
  localparam int CTRL_RSTEN     = 1;
  localparam int CTRL_INTEN     = 2;
  localparam int CTRL_PRESC_LSB = 8;

  localparam int STATUS_TO1 = 0;
  localparam int STATUS_TO2 = 1;

  // CTRL and LOAD are the only registers the lock protects.
  function automatic logic is_lockable(reg_e sel);
    return (sel == REG_CTRL) || (sel == REG_LOAD);
  endfunction

endpackage

// File: rtl/wdt_prescaler.sv
// Clock divider for the watchdog countdown: pulses tick once every presc+1
// enabled cycles; clr restarts the division from zero.
module wdt_prescaler #(
  parameter int PRESC_W = 8
) (
  input  logic               PCLK,
  input  logic               PRESETn,
  input  logic               en,
  input  logic               clr,
  input  logic [PRESC_W-1:0] presc,
  output logic               tick
);

  logic [PRESC_W-1:0] count_reg;
  logic               wrap;

  // Comparing with >= keeps the divider from running the full range when
  // the divisor is lowered below the current count.
  assign wrap = (count_reg >= presc);
  assign tick = en & ~clr & wrap;

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      count_reg <= '0;
    end else if (clr) begin
      count_reg <= '0;
    end else if (en) begin
      if (wrap) begin
        count_reg <= '0;
      end else begin
        count_reg <= count_reg + 1'b1;
      end
    end
  end

endmodule

// File: rtl/apb_watchdog_slave.sv
// APB3 watchdog slave: lockable register file, prescaled down-counter and a
// two-stage timeout (interrupt first, reset request on the second expiry).
module apb_watchdog_slave
  import wdt_pkg::*;
#(
  parameter int          PRESC_W  = 8,
  parameter logic [31:0] LOAD_RST = 32'h0000_FFFF,
  parameter int          ADDR_W   = 32
) (
  input  logic              PCLK,
  input  logic              PRESETn,
  input  logic [ADDR_W-1:0] PADDR,
  input  logic              PSEL,
  input  logic              PENABLE,
  input  logic              PWRITE,
  input  logic [31:0]       PWDATA,
  output logic [31:0]       PRDATA,
  output logic              PREADY,
  output logic              PSLVERR,
  output logic              wdt_irq,
  output logic              wdt_rst_req
);

  logic               en_reg, en_next;
  logic               rsten_reg, rsten_next;
  logic               inten_reg, inten_next;
  logic [PRESC_W-1:0] presc_reg, presc_next;
  logic [31:0]        load_reg, load_next;
  logic [31:0]        value_reg, value_next;
  logic               to1_reg, to1_next;
  logic               to2_reg, to2_next;
  logic               locked_reg, locked_next;

  reg_e        sel;
  logic        access, wr, rd;
  logic        ctrl_wr, load_wr, kick, status_wr, lock_wr;
  logic        tick, en_rise, expire;
  logic [31:0] load_eff;
  logic [1:0]  w1c;
  logic [31:0] rdata;
  logic        err;
  logic        unused_addr;

  assign unused_addr = ^{PADDR[ADDR_W-1:5], PADDR[1:0]};

  assign sel    = reg_e'(PADDR[4:2]);
  assign access = PSEL & PENABLE;
  assign wr     = access & PWRITE;
  assign rd     = access & ~PWRITE;

  assign ctrl_wr   = wr & (sel == REG_CTRL) & ~locked_reg;
  assign load_wr   = wr & (sel == REG_LOAD) & ~locked_reg;
  assign kick      = wr & (sel == REG_KICK) & (PWDATA == KICK_KEY);
  assign status_wr = wr & (sel == REG_STATUS);
  assign lock_wr   = wr & (sel == REG_LOCK);

  assign en_rise  = ctrl_wr & PWDATA[CTRL_EN] & ~en_reg;
  // A LOAD write landing on an expiry must reload with the new value.
  assign load_eff = load_wr ? PWDATA : load_reg;
  assign expire   = tick & (value_reg == 32'd0);
  assign w1c      = status_wr ? {PWDATA[STATUS_TO2], PWDATA[STATUS_TO1]} : 2'b00;

  wdt_prescaler #(
    .PRESC_W(PRESC_W)
  ) u_prescaler (
    .PCLK   (PCLK),
    .PRESETn(PRESETn),
    .en     (en_reg),
    .clr    (en_rise),
    .presc  (presc_reg),
    .tick   (tick)
  );

  always_comb begin
    en_next     = en_reg;
    rsten_next  = rsten_reg;
    inten_next  = inten_reg;
    presc_next  = presc_reg;
    load_next   = load_eff;
    value_next  = value_reg;
    locked_next = locked_reg;

    if (ctrl_wr) begin
      en_next    = PWDATA[CTRL_EN];
      rsten_next = PWDATA[CTRL_RSTEN];
      inten_next = PWDATA[CTRL_INTEN];
      presc_next = PWDATA[CTRL_PRESC_LSB +: PRESC_W];
    end

    if (en_rise || kick) begin
      value_next = load_eff;
    end else if (tick) begin
      value_next = expire ? load_eff : value_reg - 32'd1;
    end

    // A kick suppresses this cycle's expiry; hardware sets beat W1C clears.
    to1_next = (expire & ~to1_reg & ~kick) | (to1_reg & ~w1c[0] & ~kick);
    to2_next = (expire & to1_reg & ~kick) | (to2_reg & ~w1c[1]);

    if (lock_wr) begin
      locked_next = (PWDATA != UNLOCK_KEY);
    end
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      en_reg     <= 1'b0;
      rsten_reg  <= 1'b0;
      inten_reg  <= 1'b0;
      presc_reg  <= '0;
      load_reg   <= LOAD_RST;
      value_reg  <= LOAD_RST;
      to1_reg    <= 1'b0;
      to2_reg    <= 1'b0;
      locked_reg <= 1'b0;
    end else begin
      en_reg     <= en_next;
      rsten_reg  <= rsten_next;
      inten_reg  <= inten_next;
      presc_reg  <= presc_next;
      load_reg   <= load_next;
      value_reg  <= value_next;
      to1_reg    <= to1_next;
      to2_reg    <= to2_next;
      locked_reg <= locked_next;
    end
  end

  always_comb begin
    rdata = '0;
    err   = 1'b0;
    case (sel)
      REG_CTRL: begin
        rdata[CTRL_EN]                     = en_reg;
        rdata[CTRL_RSTEN]                  = rsten_reg;
        rdata[CTRL_INTEN]                  = inten_reg;
        rdata[CTRL_PRESC_LSB +: PRESC_W]   = presc_reg;
        err                                = PWRITE & locked_reg;
      end
      REG_LOAD: begin
        rdata = load_reg;
        err   = PWRITE & locked_reg;
      end
      REG_VALUE: begin
        rdata = value_reg;
        err   = PWRITE;
      end
      REG_KICK: begin
        rdata = '0;
      end
      REG_STATUS: begin
        rdata[STATUS_TO1] = to1_reg;
        rdata[STATUS_TO2] = to2_reg;
      end
      REG_LOCK: begin
        rdata[0] = locked_reg;
      end
      default: begin
        err = 1'b1;
      end
    endcase
    if (is_lockable(sel) && !locked_reg) begin
      err = 1'b0;
    end
  end

  assign PRDATA      = rd ? rdata : 32'd0;
  assign PREADY      = access;
  assign PSLVERR     = access & err;
  assign wdt_irq     = to1_reg & inten_reg;
  assign wdt_rst_req = to2_reg & rsten_reg;

endmodule
